// File: rtl/cdf_pkg.sv
// Shared constants and state encoding for the CDF stage of the histogram-equalization pipeline.
package cdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cdf_state_t;

  localparam int CDF_BINS    = 256;
  localparam int CDF_ADDR_W  = 16;
  localparam int CDF_COUNT_W = 20;

endpackage

// File: rtl/cdf_hist_reader_if.sv
// Histogram SRAM port plus the bin stream toward the CDF accumulator.
interface cdf_hist_reader_if #(
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 20
);

  logic               HistReadEn;
  logic [ADDR_W-1:0]  HistReadAddress;
  logic [COUNT_W-1:0] HistData;
  logic               HistWriteEn;
  logic [ADDR_W-1:0]  HistWriteAddress;
  logic [COUNT_W-1:0] HistWriteData;
  logic [COUNT_W-1:0] AccumlateOut;
  logic [ADDR_W-1:0]  StoreAddressOut;
  logic               StartOut;

  modport master (
    output HistReadEn, HistReadAddress, HistWriteEn, HistWriteAddress, HistWriteData,
    output AccumlateOut, StoreAddressOut, StartOut,
    input  HistData
  );

  modport slave (
    input  HistReadEn, HistReadAddress, HistWriteEn, HistWriteAddress, HistWriteData,
    input  AccumlateOut, StoreAddressOut, StartOut,
    output HistData
  );

endinterface

// File: rtl/cdf_hist_reader_valid_delay.sv
// Tags returning SRAM data: shifts {valid, bin index} by the SRAM read latency.
module cdf_valid_delay #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      idx_q[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/cdf_hist_reader.sv
// Sweeps the histogram SRAM one bin per cycle and streams gap-free counts to the CDF accumulator.
//   state | meaning
//   IDLE  | waiting for Go, base address latched on accept
//   ISSUE | one SRAM read per cycle, bins 0..BINS-1
//   DRAIN | last reads returning, RD_LAT+1 cycles
//   DONE  | one-cycle completion pulse
module cdf_hist_reader
  import cdf_pkg::*;
#(
  parameter int BINS             = CDF_BINS,
  parameter int ADDR_W           = CDF_ADDR_W,
  parameter int COUNT_W          = CDF_COUNT_W,
  parameter int RD_LAT           = 1,
  parameter bit CLEAR_AFTER_READ = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Go,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] BaseAddressIn,
  cdf_hist_reader_if.master hist,
  output logic              Busy,
  output logic              Done
);

  // One extra bit so the counter can hold BINS itself (BINS=65536 terminates).
  localparam int IDX_W = $clog2(BINS) + 1;

  cdf_state_t         state_q, state_d;
  logic [IDX_W-1:0]   bin_q, bin_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [1:0]         drain_q, drain_d;
  logic               issue;
  logic               tag_valid;
  logic [IDX_W-1:0]   tag_idx;
  logic               start_q;
  logic [COUNT_W-1:0] acc_q;
  logic [ADDR_W-1:0]  store_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      base_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      base_q  <= base_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    base_d  = base_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (Go && !Abort) begin
          state_d = ISSUE;
          base_d  = BaseAddressIn;
          bin_d   = '0;
        end
      end
      ISSUE: begin
        bin_d = bin_q + 1'b1;
        if (bin_q == IDX_W'(BINS - 1)) begin
          state_d = DRAIN;
          drain_d = 2'(RD_LAT);
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) state_d = DONE;
        else                 drain_d = drain_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Abort && state_q != IDLE) state_d = IDLE;
  end

  assign issue = (state_q == ISSUE);

  cdf_valid_delay #(
    .DEPTH (RD_LAT),
    .IDX_W (IDX_W)
  ) u_valid_delay (
    .clock     (clock),
    .reset     (reset),
    .clear     (Abort),
    .in_valid  (issue),
    .in_idx    (bin_q),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  // Outputs are forced to zero outside the Start window so the accumulator sees clean idle values.
  always_ff @(posedge clock) begin
    if (reset || Abort) begin
      start_q <= 1'b0;
      acc_q   <= '0;
      store_q <= '0;
    end else begin
      start_q <= tag_valid;
      acc_q   <= tag_valid ? hist.HistData : '0;
      store_q <= tag_valid ? ADDR_W'(tag_idx) : '0;
    end
  end

  assign hist.HistReadEn       = issue;
  assign hist.HistReadAddress  = issue ? base_q + ADDR_W'(bin_q) : '0;
  assign hist.HistWriteEn      = CLEAR_AFTER_READ && tag_valid;
  assign hist.HistWriteAddress = (CLEAR_AFTER_READ && tag_valid) ? base_q + ADDR_W'(tag_idx) : '0;
  assign hist.HistWriteData    = '0;
  assign hist.AccumlateOut     = acc_q;
  assign hist.StoreAddressOut  = store_q;
  assign hist.StartOut         = start_q;

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_cdf_hist_reader.sv
// Directed bench for cdf_hist_reader: one 256-bin RD_LAT=1 clearing instance, one 16-bin RD_LAT=2 non-clearing instance.
module tb_cdf_hist_reader;
  import cdf_pkg::*;

  typedef struct {
    int          cyc;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic        start;
    logic [19:0] acc;
    logic [15:0] idx;
    logic        busy;
    logic        done;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        go1 = 1'b0, abort1 = 1'b0, go2 = 1'b0, abort2 = 1'b0;
  logic [15:0] base1 = 16'h1000, base2 = 16'hFFFE;
  logic        busy1, done1, busy2, done2;
  logic        pre1 = 1'b0, pre2 = 1'b0;
  logic [19:0] rd1, rd2a, rd2b;
  logic [19:0] mem1 [65536];
  logic [19:0] mem2 [65536];
  int          wr2_cnt = 0;

  cdf_hist_reader_if #(.ADDR_W(16), .COUNT_W(20)) h1 ();
  cdf_hist_reader_if #(.ADDR_W(16), .COUNT_W(20)) h2 ();

  cdf_hist_reader #(
    .BINS(256), .ADDR_W(16), .COUNT_W(20), .RD_LAT(1), .CLEAR_AFTER_READ(1'b1)
  ) u_dut1 (
    .clock(clock), .reset(reset), .Go(go1), .Abort(abort1), .BaseAddressIn(base1),
    .hist(h1), .Busy(busy1), .Done(done1)
  );

  cdf_hist_reader #(
    .BINS(16), .ADDR_W(16), .COUNT_W(20), .RD_LAT(2), .CLEAR_AFTER_READ(1'b0)
  ) u_dut2 (
    .clock(clock), .reset(reset), .Go(go2), .Abort(abort2), .BaseAddressIn(base2),
    .hist(h2), .Busy(busy2), .Done(done2)
  );

  // SRAM models: bin k of dut1 holds k; dut2 bins 0..9 = 0, bin 10 = 5, bins 11..15 = k.
  function automatic logic [19:0] bin2_val(input int k);
    if (k < 10)  return 20'd0;
    if (k == 10) return 20'd5;
    return 20'(k);
  endfunction

  always @(posedge clock) begin
    if (pre1) begin
      for (int a = 0; a < 256; a++) mem1[16'(16'h1000 + a)] <= 20'(a);
    end else if (h1.HistWriteEn) begin
      mem1[h1.HistWriteAddress] <= h1.HistWriteData;
    end
    if (h1.HistReadEn) rd1 <= mem1[h1.HistReadAddress];
  end
  assign h1.HistData = rd1;

  always @(posedge clock) begin
    if (pre2) begin
      for (int a = 0; a < 16; a++) mem2[16'(16'hFFFE + a)] <= bin2_val(a);
    end else if (h2.HistWriteEn) begin
      mem2[h2.HistWriteAddress] <= h2.HistWriteData;
    end
    if (h2.HistReadEn) rd2a <= mem2[h2.HistReadAddress];
    rd2b <= rd2a;
    if (h2.HistWriteEn) wr2_cnt <= wr2_cnt + 1;
  end
  assign h2.HistData = rd2b;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int rd_cnt, s_cnt, s_first, s_last, sum, bad, d_cnt, d_cyc, b_cnt, min_val, min_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic clear_stats();
    rd_cnt = 0; s_cnt = 0; s_first = -1; s_last = -1; sum = 0; bad = 0;
    d_cnt = 0; d_cyc = -1; b_cnt = 0; min_val = -1; min_idx = -1;
  endtask

  task automatic check_all_zero1(input string tag);
    check({tag, " rd_en"},   32'(h1.HistReadEn), 0);
    check({tag, " rd_addr"}, 32'(h1.HistReadAddress), 0);
    check({tag, " wr_en"},   32'(h1.HistWriteEn), 0);
    check({tag, " wr_addr"}, 32'(h1.HistWriteAddress), 0);
    check({tag, " wr_data"}, 32'(h1.HistWriteData), 0);
    check({tag, " start"},   32'(h1.StartOut), 0);
    check({tag, " acc"},     32'(h1.AccumlateOut), 0);
    check({tag, " idx"},     32'(h1.StoreAddressOut), 0);
    check({tag, " busy"},    32'(busy1), 0);
    check({tag, " done"},    32'(done1), 0);
  endtask

  // Bin i is presented in cycle 3+i; its content is i before clearing and 0 after.
  task automatic observe1(input bit cleared);
    if (h1.HistReadEn) rd_cnt++;
    if (busy1) b_cnt++;
    if (done1) begin d_cnt++; d_cyc = cyc; end
    if (h1.StartOut) begin
      if (s_cnt == 0) s_first = cyc;
      s_last = cyc;
      s_cnt++;
      sum += int'(h1.AccumlateOut);
      if (h1.StoreAddressOut != 16'(cyc - 3)) bad++;
      if (h1.AccumlateOut != (cleared ? 20'd0 : 20'(cyc - 3))) bad++;
    end
  endtask

  task automatic observe2();
    if (h2.HistReadEn) begin
      rd_cnt++;
      if (h2.HistReadAddress != 16'(16'hFFFE + cyc - 1)) bad++;
    end
    if (busy2) b_cnt++;
    if (done2) begin d_cnt++; d_cyc = cyc; end
    if (h2.StartOut) begin
      if (s_cnt == 0) s_first = cyc;
      s_last = cyc;
      s_cnt++;
      sum += int'(h2.AccumlateOut);
      if (h2.StoreAddressOut != 16'(cyc - 4)) bad++;
      if (h2.AccumlateOut != bin2_val(cyc - 4)) bad++;
      if (min_val < 0 && h2.AccumlateOut != 0) begin
        min_val = int'(h2.AccumlateOut);
        min_idx = int'(h2.StoreAddressOut);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, test did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cyc  rd    rd_addr   wr    wr_addr   start acc   idx   busy  done
    tbl[0] = '{  1,  1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 20'd0,   16'd0,   1'b1, 1'b0};
    tbl[1] = '{  2,  1'b1, 16'h1001, 1'b1, 16'h1000, 1'b0, 20'd0,   16'd0,   1'b1, 1'b0};
    tbl[2] = '{  3,  1'b1, 16'h1002, 1'b1, 16'h1001, 1'b1, 20'd0,   16'd0,   1'b1, 1'b0};
    tbl[3] = '{  4,  1'b1, 16'h1003, 1'b1, 16'h1002, 1'b1, 20'd1,   16'd1,   1'b1, 1'b0};
    tbl[4] = '{130,  1'b1, 16'h1081, 1'b1, 16'h1080, 1'b1, 20'd127, 16'd127, 1'b1, 1'b0};
    tbl[5] = '{256,  1'b1, 16'h10FF, 1'b1, 16'h10FE, 1'b1, 20'd253, 16'd253, 1'b1, 1'b0};
    tbl[6] = '{257,  1'b0, 16'h0000, 1'b1, 16'h10FF, 1'b1, 20'd254, 16'd254, 1'b1, 1'b0};
    tbl[7] = '{258,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 20'd255, 16'd255, 1'b1, 1'b0};
    tbl[8] = '{259,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 20'd0,   16'd0,   1'b1, 1'b1};
    tbl[9] = '{260,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 20'd0,   16'd0,   1'b0, 1'b0};

    // Reset with SRAM preload
    pre1 = 1'b1; pre2 = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    pre1 = 1'b0; pre2 = 1'b0;
    check_all_zero1("reset");
    check("reset busy2", 32'(busy2), 0);
    reset = 1'b0;
    step();

    // Sweep 1: full read of 256 bins, table plus window statistics
    clear_stats();
    go1 = 1'b1; cyc = 0; step(); go1 = 1'b0;
    while (cyc <= 261) begin
      for (int t = 0; t < NV; t++) begin
        if (tbl[t].cyc == cyc) begin
          check($sformatf("s1 c%0d rd_en", cyc),   32'(h1.HistReadEn),       32'(tbl[t].rd_en));
          check($sformatf("s1 c%0d rd_addr", cyc), 32'(h1.HistReadAddress),  32'(tbl[t].rd_addr));
          check($sformatf("s1 c%0d wr_en", cyc),   32'(h1.HistWriteEn),      32'(tbl[t].wr_en));
          check($sformatf("s1 c%0d wr_addr", cyc), 32'(h1.HistWriteAddress), 32'(tbl[t].wr_addr));
          check($sformatf("s1 c%0d start", cyc),   32'(h1.StartOut),         32'(tbl[t].start));
          check($sformatf("s1 c%0d acc", cyc),     32'(h1.AccumlateOut),     32'(tbl[t].acc));
          check($sformatf("s1 c%0d idx", cyc),     32'(h1.StoreAddressOut),  32'(tbl[t].idx));
          check($sformatf("s1 c%0d busy", cyc),    32'(busy1),               32'(tbl[t].busy));
          check($sformatf("s1 c%0d done", cyc),    32'(done1),               32'(tbl[t].done));
        end
      end
      observe1(1'b0);
      step();
    end
    check("s1 start count", 32'(s_cnt), 256);
    check("s1 start first", 32'(s_first), 3);
    check("s1 start last", 32'(s_last), 258);
    check("s1 accum sum", 32'(sum), 32640);
    check("s1 bin data errors", 32'(bad), 0);
    check("s1 read count", 32'(rd_cnt), 256);
    check("s1 done count", 32'(d_cnt), 1);
    check("s1 done cycle", 32'(d_cyc), 259);
    check("s1 busy cycles", 32'(b_cnt), 259);
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem1[16'(16'h1000 + a)] != 20'd0) bad++;
    check("s1 bins not cleared", 32'(bad), 0);

    // Sweep 2: Go held high throughout, including the Done cycle
    clear_stats();
    go1 = 1'b1; cyc = 0; step();
    while (cyc <= 265) begin
      if (cyc == 260) go1 = 1'b0;
      observe1(1'b1);
      step();
    end
    check("s2 start count", 32'(s_cnt), 256);
    check("s2 start first", 32'(s_first), 3);
    check("s2 start last", 32'(s_last), 258);
    check("s2 accum sum", 32'(sum), 0);
    check("s2 bin data errors", 32'(bad), 0);
    check("s2 read count", 32'(rd_cnt), 256);
    check("s2 done count", 32'(d_cnt), 1);
    check("s2 done cycle", 32'(d_cyc), 259);
    check("s2 busy cycles", 32'(b_cnt), 259);

    // Sweep 3: abort at cycle 50
    go1 = 1'b1; cyc = 0; step(); go1 = 1'b0;
    while (cyc < 50) step();
    check("ab c50 start", 32'(h1.StartOut), 1);
    check("ab c50 idx", 32'(h1.StoreAddressOut), 47);
    check("ab c50 rd_addr", 32'(h1.HistReadAddress), 32'h1031);
    check("ab c50 wr_addr", 32'(h1.HistWriteAddress), 32'h1030);
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    check_all_zero1("ab c51");
    clear_stats();
    repeat (300) begin
      observe1(1'b1);
      step();
    end
    check("ab after done", 32'(d_cnt), 0);
    check("ab after busy", 32'(b_cnt), 0);
    check("ab after reads", 32'(rd_cnt), 0);
    check("ab after starts", 32'(s_cnt), 0);

    // Sweep 4: restart from bin 0, then synchronous reset at cycle 100
    go1 = 1'b1; cyc = 0; step(); go1 = 1'b0;
    check("rs c1 rd_en", 32'(h1.HistReadEn), 1);
    check("rs c1 rd_addr", 32'(h1.HistReadAddress), 32'h1000);
    step(); step();
    check("rs c3 start", 32'(h1.StartOut), 1);
    check("rs c3 idx", 32'(h1.StoreAddressOut), 0);
    while (cyc < 100) step();
    reset = 1'b1;
    step();
    check_all_zero1("rs c101");
    reset = 1'b0;
    clear_stats();
    repeat (300) begin
      observe1(1'b1);
      step();
    end
    check("rs after done", 32'(d_cnt), 0);
    check("rs after busy", 32'(b_cnt), 0);
    check("rs after starts", 32'(s_cnt), 0);

    // Sweep 5: RD_LAT=2, wrapping base 0xFFFE, no clearing
    clear_stats();
    go2 = 1'b1; cyc = 0; step(); go2 = 1'b0;
    while (cyc <= 24) begin
      if (cyc == 1) check("w c1 rd_addr", 32'(h2.HistReadAddress), 32'hFFFE);
      if (cyc == 2) check("w c2 rd_addr", 32'(h2.HistReadAddress), 32'hFFFF);
      if (cyc == 3) check("w c3 rd_addr", 32'(h2.HistReadAddress), 32'h0000);
      if (cyc == 4) check("w c4 rd_addr", 32'(h2.HistReadAddress), 32'h0001);
      observe2();
      step();
    end
    check("w read count", 32'(rd_cnt), 16);
    check("w start first", 32'(s_first), 4);
    check("w start last", 32'(s_last), 19);
    check("w start count", 32'(s_cnt), 16);
    check("w data/addr errors", 32'(bad), 0);
    check("w accum sum", 32'(sum), 70);
    check("w cdf min", 32'(min_val), 5);
    check("w cdf min bin", 32'(min_idx), 10);
    check("w done cycle", 32'(d_cyc), 20);
    check("w done count", 32'(d_cnt), 1);
    check("w busy cycles", 32'(b_cnt), 20);
    check("w write strobes", 32'(wr2_cnt), 0);
    bad = 0;
    for (int a = 0; a < 16; a++) if (mem2[16'(16'hFFFE + a)] != bin2_val(a)) bad++;
    check("w sram changed", 32'(bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
